// File: rtl/board_pkg.sv
// Shared types, constants and helpers for the 4x4 board controller.
package board_pkg;

  localparam int unsigned N_CELLS = 16;
  localparam int unsigned N_LINES = 10;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P0    = 2'b01,
    P1    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    S_TURN  = 2'b00,
    S_CHECK = 2'b01,
    S_OVER  = 2'b10
  } state_t;

  typedef logic [3:0] cell_idx_t;

  // Rows, then columns, then the two diagonals.
  localparam cell_idx_t LINE_IDX [N_LINES][4] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3 },
    '{4'd4,  4'd5,  4'd6,  4'd7 },
    '{4'd8,  4'd9,  4'd10, 4'd11},
    '{4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd1,  4'd5,  4'd9,  4'd13},
    '{4'd2,  4'd6,  4'd10, 4'd14},
    '{4'd3,  4'd7,  4'd11, 4'd15},
    '{4'd0,  4'd5,  4'd10, 4'd15},
    '{4'd3,  4'd6,  4'd9,  4'd12}
  };

  function automatic cell_t cell_at(input logic [2*N_CELLS-1:0] b, input cell_idx_t i);
    return cell_t'(b[{i, 1'b0} +: 2]);
  endfunction

  function automatic cell_t player_mark(input logic player);
    return player ? P1 : P0;
  endfunction

endpackage

// File: rtl/board_line_check.sv
// Combinational win/full evaluation over the packed 16-cell board.
module board_line_check
  import board_pkg::*;
(
  input  logic [2*N_CELLS-1:0] board,
  output logic                 win,
  output cell_t                mark,
  output logic                 full
);

  cell_t c0, c1, c2, c3;

  always_comb begin
    win  = 1'b0;
    mark = EMPTY;
    full = 1'b1;
    c0   = EMPTY;
    c1   = EMPTY;
    c2   = EMPTY;
    c3   = EMPTY;
    for (int unsigned k = 0; k < N_CELLS; k++) begin
      if (cell_at(board, cell_idx_t'(k)) == EMPTY) full = 1'b0;
    end
    for (int unsigned l = 0; l < N_LINES; l++) begin
      c0 = cell_at(board, LINE_IDX[l][0]);
      c1 = cell_at(board, LINE_IDX[l][1]);
      c2 = cell_at(board, LINE_IDX[l][2]);
      c3 = cell_at(board, LINE_IDX[l][3]);
      if (!win && c0 != EMPTY && c0 == c1 && c0 == c2 && c0 == c3) begin
        win  = 1'b1;
        mark = c0;
      end
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Game sequencer for the 4x4 VGA board: cursor, moves, win/draw, frame-synced display.
// Optional per-turn timer enabled by defining TURN_TIMER_EN.
module board_ctrl
  import board_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 250_000_000,
  parameter int unsigned TIMER_W      = 28
)(
  input  logic        VGA_CLK_IN,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_btn_next,
  input  logic        i_btn_sel,
  input  logic        i_new_game,
  output logic [31:0] o_board,
  output logic [3:0]  o_block,
  output logic        o_player,
  output logic [1:0]  o_winner,
  output logic        o_draw,
  output logic        o_game_over,
  output logic        o_move_err,
  output logic        o_timeout
);

  if (TURN_TIMEOUT == 0 || (TIMER_W < 32 && TURN_TIMEOUT >= (32'd1 << TIMER_W))) begin : g_bad_timer
    $error("board_ctrl: TIMER_W too narrow for TURN_TIMEOUT");
  end

  state_t               state_q, state_d;
  logic [2*N_CELLS-1:0] board_q, board_d;
  cell_idx_t            cursor_q, cursor_d;
  logic                 player_q, player_d;
  cell_t                winner_q, winner_d;
  logic                 draw_q, draw_d;
  logic                 move_err_q, move_err_d;
  logic                 timeout_q, timeout_d;

  logic [2*N_CELLS-1:0] disp_board_q;
  cell_idx_t            disp_block_q;
  logic                 disp_player_q;

  logic  line_win, board_full, sel_free, turn_expired;
  cell_t line_mark;

  board_line_check u_line_check (
    .board (board_q),
    .win   (line_win),
    .mark  (line_mark),
    .full  (board_full)
  );

  assign sel_free = i_btn_sel && (cell_at(board_q, cursor_q) == EMPTY);

`ifdef TURN_TIMER_EN
  logic [TIMER_W-1:0] timer_q;

  assign turn_expired = (state_q == S_TURN) && (timer_q == TIMER_W'(TURN_TIMEOUT - 1));

  // Holding the counter at zero outside S_TURN makes every entry start a fresh turn.
  always_ff @(posedge VGA_CLK_IN) begin
    if (i_rst || i_new_game || state_q != S_TURN || turn_expired) timer_q <= '0;
    else                                                          timer_q <= timer_q + 1'b1;
  end
`else
  assign turn_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    cursor_d   = cursor_q;
    player_d   = player_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    move_err_d = 1'b0;
    timeout_d  = 1'b0;
    if (i_new_game) begin
      board_d  = '0;
      player_d = 1'b0;
      winner_d = EMPTY;
      draw_d   = 1'b0;
      state_d  = S_TURN;
    end else begin
      if (i_btn_next) cursor_d = cursor_q + 1'b1;
      case (state_q)
        S_TURN: begin
          if (sel_free) begin
            board_d[{cursor_q, 1'b0} +: 2] = player_mark(player_q);
            state_d = S_CHECK;
          end else begin
            move_err_d = i_btn_sel;
            if (turn_expired) begin
              timeout_d = 1'b1;
              player_d  = ~player_q;
            end
          end
        end
        S_CHECK: begin
          if (line_win) begin
            winner_d = line_mark;
            state_d  = S_OVER;
          end else if (board_full) begin
            draw_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            player_d = ~player_q;
            state_d  = S_TURN;
          end
        end
        S_OVER: ;
        default: state_d = S_TURN;
      endcase
    end
  end

  always_ff @(posedge VGA_CLK_IN) begin
    if (i_rst) begin
      state_q    <= S_TURN;
      board_q    <= '0;
      cursor_q   <= '0;
      player_q   <= 1'b0;
      winner_q   <= EMPTY;
      draw_q     <= 1'b0;
      move_err_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      cursor_q   <= cursor_d;
      player_q   <= player_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      move_err_q <= move_err_d;
      timeout_q  <= timeout_d;
    end
  end

  // Renderer-facing copies change only at frame start so a frame never tears.
  always_ff @(posedge VGA_CLK_IN) begin
    if (i_rst) begin
      disp_board_q  <= '0;
      disp_block_q  <= '0;
      disp_player_q <= 1'b0;
    end else if (i_frame_start) begin
      disp_board_q  <= board_q;
      disp_block_q  <= cursor_q;
      disp_player_q <= player_q;
    end
  end

  assign o_board     = disp_board_q;
  assign o_block     = disp_block_q;
  assign o_player    = disp_player_q;
  assign o_winner    = winner_q;
  assign o_draw      = draw_q;
  assign o_game_over = (state_q == S_OVER);
  assign o_move_err  = move_err_q;
  assign o_timeout   = timeout_q;

endmodule
